// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative radix-256 integer multiplier with early termination
//
// Executes MUL/MLA (32-bit result) and UMULL/UMLAL/SMULL/SMLAL (64-bit result).
// Each step cycle retires STEP_BITS multiplier bits. The operation stops as soon
// as the unretired multiplier bits are all zero or, in signed mode, all ones.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   start                 request an operation; ignored while busy
//   is_long, is_signed    result width and signedness (is_signed only for long)
//   accumulate            add acc_hi:acc_lo (acc_lo only for short ops)
//   op_a, op_b            multiplicand (Rm) and multiplier (Rs)
//   acc_lo, acc_hi        accumulate words
//   busy                  step cycles in progress
//   done                  one-cycle pulse when results become valid
//   result_lo, result_hi  product; result_hi is 0 for short ops
//   flag_n, flag_z        N/Z flags of the result
//   steps                 step cycles used by the last completed operation
module mul_unit #(
  parameter int STEP_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_long,
  input  logic        is_signed,
  input  logic        accumulate,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        flag_n,
  output logic        flag_z,
  output logic [2:0]  steps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operation context captured at the accepting edge.
  logic        signed_mode;
  logic        long_q;
  logic [63:0] acc64;
  logic [63:0] mcand;
  logic [32:0] rem;
  logic [5:0]  shift;
  logic [2:0]  step_cnt;

  logic        start_signed;
  logic        accept;

  logic [63:0] partial;
  logic [63:0] t_sum;
  logic [63:0] corr;
  logic [63:0] final_val;
  logic [32:0] nrem;
  logic        last_step;

  // Short multiplies use the signed termination rule; their low word is the
  // same whichever extension is chosen.
  assign start_signed = is_long ? is_signed : 1'b1;
  assign accept       = start && (state != STEP);

  assign busy = (state == STEP);
  assign done = (state == DONE);

  // One radix-2^STEP_BITS step. The low multiplier digit is always treated as
  // unsigned; the sign of a signed multiplier is carried by the remaining bits
  // and settled by the correction term when those bits are all ones.
  always_comb begin
    partial   = mcand * {{(64 - STEP_BITS){1'b0}}, rem[STEP_BITS-1:0]};
    t_sum     = acc64 + (partial << shift);
    nrem      = signed_mode ? 33'($signed(rem) >>> STEP_BITS) : (rem >> STEP_BITS);
    corr      = mcand << (shift + 6'(STEP_BITS));
    final_val = t_sum;
    last_step = 1'b0;
    if (nrem == '0) begin
      last_step = 1'b1;
    end else if (signed_mode && (&nrem)) begin
      // Remaining multiplier value is -1 at weight 2^(shift+STEP_BITS).
      last_step = 1'b1;
      final_val = t_sum - corr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (start) begin
          state_nxt = STEP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signed_mode <= 1'b0;
      long_q      <= 1'b0;
      acc64       <= '0;
      mcand       <= '0;
      rem         <= '0;
      shift       <= '0;
      step_cnt    <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      steps       <= '0;
    end else if (accept) begin
      signed_mode <= start_signed;
      long_q      <= is_long;
      acc64       <= accumulate ? {(is_long ? acc_hi : 32'd0), acc_lo} : 64'd0;
      mcand       <= start_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
      rem         <= start_signed ? {op_b[31], op_b} : {1'b0, op_b};
      shift       <= '0;
      step_cnt    <= 3'd1;
    end else if (state == STEP) begin
      if (last_step) begin
        // Results and flags hold until the next operation completes.
        result_lo <= final_val[31:0];
        result_hi <= long_q ? final_val[63:32] : 32'd0;
        flag_n    <= long_q ? final_val[63] : final_val[31];
        flag_z    <= long_q ? (final_val == 64'd0) : (final_val[31:0] == 32'd0);
        steps     <= step_cnt;
      end else begin
        acc64    <= t_sum;
        rem      <= nrem;
        shift    <= shift + 6'(STEP_BITS);
        step_cnt <= step_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - self-checking bench for mul_unit with a behavioural model
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_long = 1'b0;
  logic        is_signed = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] acc_lo = '0;
  logic [31:0] acc_hi = '0;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_n;
  logic        flag_z;
  logic [2:0]  steps;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_unit #(.STEP_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_long(is_long),
    .is_signed(is_signed),
    .accumulate(accumulate),
    .op_a(op_a),
    .op_b(op_b),
    .acc_lo(acc_lo),
    .acc_hi(acc_hi),
    .busy(busy),
    .done(done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flag_n(flag_n),
    .flag_z(flag_z),
    .steps(steps)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Step count: smallest number of bytes whose removal leaves a multiplier
  // remainder of 0 (or -1 when signed); never more than 4.
  function automatic int model_steps(input logic [31:0] b, input bit sgn);
    longint v;
    longint s;
    v = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    for (int k = 1; k < 4; k++) begin
      s = v >>> (8 * k);
      if (s == 0 || s == -1) return k;
    end
    return 4;
  endfunction

  function automatic logic [63:0] model_prod(input bit lng, input bit sgn, input bit acc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] ahi, input logic [31:0] alo);
    logic [63:0] p;
    logic [63:0] ac;
    if (lng && !sgn) p = {32'd0, a} * {32'd0, b};
    else p = 64'(longint'($signed(a)) * longint'($signed(b)));
    ac = acc ? {(lng ? ahi : 32'd0), alo} : 64'd0;
    p = p + ac;
    if (!lng) p[63:32] = 32'd0;
    return p;
  endfunction

  // Behavioural timing/result model: m_left counts remaining busy cycles.
  int          m_left = 0;
  bit          m_done = 0;
  logic [63:0] m_res = '0;
  logic        m_n = 1'b0;
  logic        m_z = 1'b0;
  logic [2:0]  m_steps = '0;
  logic [63:0] p_res = '0;
  logic        p_n = 1'b0;
  logic        p_z = 1'b0;
  logic [2:0]  p_steps = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_done = 0; m_res = '0; m_n = 0; m_z = 0; m_steps = '0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_res = p_res; m_n = p_n; m_z = p_z; m_steps = p_steps;
        end
      end else if (start) begin
        p_res   = model_prod(is_long, is_signed, accumulate, op_a, op_b, acc_hi, acc_lo);
        p_n     = is_long ? p_res[63] : p_res[31];
        p_z     = is_long ? (p_res == 64'd0) : (p_res[31:0] == 32'd0);
        m_left  = model_steps(op_b, is_long ? is_signed : 1'b1);
        p_steps = 3'(m_left);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("result_lo", 64'(result_lo), 64'(m_res[31:0]));
    chk("result_hi", 64'(result_hi), 64'(m_res[63:32]));
    chk("flag_n", 64'(flag_n), 64'(m_n));
    chk("flag_z", 64'(flag_z), 64'(m_z));
    chk("steps", 64'(steps), 64'(m_steps));
  end

  task automatic issue_now(input bit lng, input bit sgn, input bit acc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    #1;
    is_long = lng; is_signed = sgn; accumulate = acc;
    op_a = a; op_b = b; acc_hi = hi; acc_lo = lo;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input bit lng, input bit sgn, input bit acc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    @(posedge clk);
    issue_now(lng, sgn, acc, a, b, hi, lo);
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) break;
      if (cyc >= 20) begin
        checks++;
        failures++;
        $display("FAIL wait_done no done within 20 cycles at %0t", $time);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bc;
    int dn;
    logic [31:0] rb;
    bit lng;
    bit sgn;

    chk("pin_steps_4", 64'(model_steps(32'h12345678, 1'b1)), 64'd4);
    chk("pin_steps_3", 64'(model_steps(32'h00010000, 1'b0)), 64'd3);
    chk("pin_steps_neg", 64'(model_steps(32'hFFFFFFFF, 1'b1)), 64'd1);
    chk("pin_prod_smull", model_prod(1, 1, 0, 32'hFFFFFFFE, 32'd3, 0, 0), 64'hFFFFFFFF_FFFFFFFA);

    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_steps", 64'(steps), 64'd0);
    #2 reset = 1'b1;

    issue(0, 0, 0, 32'd7, 32'd6, 0, 0);
    wait_done(cyc, bc);
    chk("mul_lat", 64'(cyc), 64'd2);
    chk("mul_lo", 64'(result_lo), 64'd42);
    chk("mul_hi", 64'(result_hi), 64'd0);
    chk("mul_steps", 64'(steps), 64'd1);
    chk("mul_nz", 64'({flag_n, flag_z}), 64'd0);

    issue(0, 0, 0, 32'd2, 32'h12345678, 0, 0);
    wait_done(cyc, bc);
    chk("mul4_lo", 64'(result_lo), 64'h2468ACF0);
    chk("mul4_steps", 64'(steps), 64'd4);
    chk("mul4_busy", 64'(bc), 64'd4);

    issue(1, 1, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0);
    wait_done(cyc, bc);
    chk("smull_corr", {result_hi, result_lo}, 64'd2);
    chk("smull_corr_steps", 64'(steps), 64'd1);
    issue(1, 1, 0, 32'hFFFFFFFE, 32'd3, 0, 0);
    wait_done(cyc, bc);
    chk("smull_neg", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFA);
    chk("smull_neg_n", 64'(flag_n), 64'd1);

    issue(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    wait_done(cyc, bc);
    chk("umull_max", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    chk("umull_steps", 64'(steps), 64'd4);
    issue(0, 0, 0, 32'd0, 32'd5, 0, 0);
    wait_done(cyc, bc);
    chk("mul_zero_z", 64'(flag_z), 64'd1);
    chk("mul_zero_steps", 64'(steps), 64'd1);

    issue(1, 0, 1, 32'h10000, 32'h10000, 32'd1, 32'hFFFFFFFF);
    wait_done(cyc, bc);
    chk("umlal", {result_hi, result_lo}, 64'h00000002_FFFFFFFF);
    chk("umlal_steps", 64'(steps), 64'd3);

    // MLA then back-to-back UMULL started in the done cycle.
    issue(0, 0, 1, 32'd3, 32'd4, 32'd99, 32'd10);
    wait_done(cyc, bc);
    chk("mla", 64'(result_lo), 64'd22);
    chk("mla_hi", 64'(result_hi), 64'd0);
    issue_now(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    wait_done(cyc, bc);
    chk("b2b_lat", 64'(cyc), 64'd5);
    chk("b2b_busy", 64'(bc), 64'd4);
    chk("b2b_res", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);

    // Start while busy is ignored.
    issue(0, 0, 0, 32'd2, 32'h12345678, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bc);
    chk("ign_lat", 64'(cyc), 64'd3);
    chk("ign_lo", 64'(result_lo), 64'h2468ACF0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ign_no_second", 64'(dn), 64'd0);

    // Reset in the second step cycle.
    issue(1, 0, 0, 32'h01234567, 32'h89ABCDEF, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_res", {result_hi, result_lo}, 64'd0);
    chk("arst_flags", 64'({flag_n, flag_z}), 64'd0);
    chk("arst_steps", 64'(steps), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("arst_no_done", 64'(dn), 64'd0);

    // Randomized operations; the per-cycle compare checks against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: rb = $urandom & 32'hFF;
        1: rb = $urandom & 32'hFFFF;
        2: rb = $urandom & 32'hFFFFFF;
        3: rb = $urandom;
        default: rb = 32'd0 - 32'($urandom_range(1, 70000));
      endcase
      lng = 1'($urandom);
      sgn = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        issue_now(lng, sgn, 1'($urandom), $urandom, rb, $urandom, $urandom);
      else
        issue(lng, sgn, 1'($urandom), $urandom, rb, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1 op_a = $urandom; op_b = $urandom; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_done(cyc, bc);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
